rr_select_ctrl: RTL and testbench

RR_SELECT_CTRL -- requirements
Module: rr_select_ctrl

---
 rtl/sel_pkg.sv | 14 +
 rtl/rr_select_fsm.sv | 79 +++++++
 rtl/rr_select_ctrl.sv | 78 +++++++
 tb/tb_rr_select_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sel_pkg.sv
// Shared types and constants for the round-robin packet select block.
package sel_pkg;

    // Default data width of each input channel and of the merged output.
    localparam int WIDTH_DEFAULT = 8;

    // Arbitration states: waiting for a packet, or locked onto one channel.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

endpackage

// File: rtl/rr_select_fsm.sv
// Packet-level arbiter: picks a channel in IDLE, holds the grant until the
// last beat of the packet is accepted, then flips the round-robin pointer.
module rr_select_fsm
    import sel_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   a_valid,
    input  logic   b_valid,
    input  logic   accept,
    input  logic   accept_last,
    output state_t state,
    output logic   sel,
    output logic   prio
);

    state_t r_state;
    state_t w_state_next;
    logic   r_sel;
    logic   w_sel_next;
    logic   r_prio;
    logic   w_prio_next;

    // State, grant select and priority pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_prio  <= w_prio_next;
        end
    end

    // Next-state logic; sel follows the grant and holds its value through IDLE.
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_prio_next  = r_prio;
        case (r_state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    w_state_next = r_prio ? GNT_B : GNT_A;
                end else if (a_valid) begin
                    w_state_next = GNT_A;
                end else if (b_valid) begin
                    w_state_next = GNT_B;
                end
                if (w_state_next == GNT_A) begin
                    w_sel_next = 1'b0;
                end else if (w_state_next == GNT_B) begin
                    w_sel_next = 1'b1;
                end
            end
            GNT_A: begin
                if (accept && accept_last) begin
                    w_state_next = IDLE;
                    w_prio_next  = 1'b1;
                end
            end
            GNT_B: begin
                if (accept && accept_last) begin
                    w_state_next = IDLE;
                    w_prio_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign state = r_state;
    assign sel   = r_sel;
    assign prio  = r_prio;

endmodule

// File: rtl/rr_select_ctrl.sv
// Two-channel packet merger: the arbiter picks a channel, this level muxes
// the granted channel into a single registered output stage.
module rr_select_ctrl
    import sel_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel
);

    state_t           w_state;
    logic             w_sel;
    logic             w_prio_unused;
    logic             w_can_load;
    logic             w_accept;
    logic [WIDTH-1:0] w_mux_data;
    logic             w_mux_last;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;

    rr_select_fsm u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .b_valid     (b_valid),
        .accept      (w_accept),
        .accept_last (w_mux_last),
        .state       (w_state),
        .sel         (w_sel),
        .prio        (w_prio_unused)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign w_can_load = !r_out_valid || out_ready;
    assign a_ready    = (w_state == GNT_A) && w_can_load;
    assign b_ready    = (w_state == GNT_B) && w_can_load;
    assign w_accept   = (a_valid && a_ready) || (b_valid && b_ready);

    // sel already points at the granted channel whenever a beat can be accepted.
    assign w_mux_data = w_sel ? b_data : a_data;
    assign w_mux_last = w_sel ? b_last : a_last;

    // Output register: load on accept, clear when drained with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
            r_out_last  <= w_mux_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign sel       = w_sel;

endmodule

// File: tb/tb_rr_select_ctrl.sv
// Testbench for rr_select_ctrl: directed scenarios plus randomized packet
// traffic checked against a packet-order reference model.
module tb_rr_select_ctrl;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       ch;
    } exp_t;

    typedef struct packed {
        logic       ov;
        logic [7:0] od;
        logic       ol;
        logic       ordy;
        logic       ar;
        logic       br;
        logic       bv;
        logic       sl;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0;
    logic [7:0] a_data = '0;
    logic       a_last = 1'b0;
    logic       a_ready;
    logic       b_valid = 1'b0;
    logic [7:0] b_data = '0;
    logic       b_last = 1'b0;
    logic       b_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       sel;

    int errors = 0;
    int checks = 0;

    beat_t a_q[$];
    beat_t b_q[$];
    beat_t rx[$];
    int    rx_cyc[$];
    bit    acc_ch[$];
    bit    acc_sel[$];
    bit    acc_last[$];
    snap_t snaps[$];
    exp_t  exp_q[$];
    bit    m_prio = 1'b0;
    bit    timed_out = 1'b0;

    rr_select_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    // Queue one packet of len beats on a channel (incrementing or random data).
    task automatic push_pkt(input bit ch, input int len, input logic [7:0] base, input bit rnd);
        beat_t bt;
        for (int i = 0; i < len; i++) begin
            bt.d = rnd ? 8'($urandom_range(255)) : 8'(base + 8'(i));
            bt.l = (i == len - 1);
            if (ch) b_q.push_back(bt);
            else    a_q.push_back(bt);
        end
    endtask

    // Reference model: whole packets in grant order, alternating on ties.
    function automatic void build_expected(input beat_t qa[$], input beat_t qb[$]);
        int ia = 0;
        int ib = 0;
        bit ch;
        bit done;
        exp_t e;
        exp_q.delete();
        while (ia < qa.size() || ib < qb.size()) begin
            if (ia < qa.size() && ib < qb.size()) ch = m_prio;
            else ch = (ia < qa.size()) ? 1'b0 : 1'b1;
            done = 1'b0;
            while (!done) begin
                if (ch) begin e.d = qb[ib].d; e.l = qb[ib].l; ib++; end
                else    begin e.d = qa[ia].d; e.l = qa[ia].l; ia++; end
                e.ch = ch;
                exp_q.push_back(e);
                done = e.l;
            end
            m_prio = !ch;
        end
    endfunction

    // Drive queued packets with continuous valid, record per-cycle snapshots.
    task automatic run(input int pct, input int stall, input int b_delay, input int budget);
        int cyc = 0;
        snaps.delete(); rx.delete(); rx_cyc.delete();
        acc_ch.delete(); acc_sel.delete(); acc_last.delete();
        timed_out = 1'b0;
        forever begin
            a_valid = (a_q.size() > 0);
            a_data  = a_valid ? a_q[0].d : 8'h00;
            a_last  = a_valid ? a_q[0].l : 1'b0;
            b_valid = (cyc >= b_delay) && (b_q.size() > 0);
            b_data  = b_valid ? b_q[0].d : 8'h00;
            b_last  = b_valid ? b_q[0].l : 1'b0;
            out_ready = (cyc >= stall) && (int'($urandom_range(99)) < pct);
            @(negedge clk);
            snaps.push_back('{out_valid, out_data, out_last, out_ready, a_ready, b_ready, b_valid, sel});
            if (out_valid && out_ready) begin
                rx.push_back('{out_data, out_last});
                rx_cyc.push_back(cyc);
            end
            if (a_valid && a_ready) begin
                acc_ch.push_back(1'b0); acc_sel.push_back(sel); acc_last.push_back(a_q[0].l);
                void'(a_q.pop_front());
            end
            if (b_valid && b_ready) begin
                acc_ch.push_back(1'b1); acc_sel.push_back(sel); acc_last.push_back(b_q[0].l);
                void'(b_q.pop_front());
            end
            @(posedge clk);
            #1;
            cyc++;
            if (a_q.size() == 0 && b_q.size() == 0 && !out_valid) break;
            if (cyc >= budget) begin
                timed_out = 1'b1;
                a_q.delete();
                b_q.delete();
                break;
            end
        end
        a_valid = 1'b0; a_last = 1'b0;
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid);
        checks++; if (out_data !== 8'h00) $display("FAIL rst_out_data: got %0h want 0", out_data);
        checks++; if (out_last !== 1'b0) $display("FAIL rst_out_last: got %0b want 0", out_last);
        checks++; if (sel !== 1'b0) $display("FAIL rst_sel: got %0b want 0", sel);
        checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL rst_ready: got a=%0b b=%0b want 0 0", a_ready, b_ready);
        errors += (out_valid !== 1'b0) + (out_data !== 8'h00) + (out_last !== 1'b0) + (sel !== 1'b0)
                + (a_ready !== 1'b0 || b_ready !== 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // One A packet moves the priority pointer to B before the mid-packet reset.
        push_pkt(0, 1, 8'h01, 0);
        build_expected(a_q, b_q);
        run(100, 0, 0, 50);
        b_valid = 1'b1; b_data = 8'h33; b_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h33) begin errors++; $display("FAIL rst_preload: got v=%0b d=%0h want v=1 d=33", out_valid, out_data); end
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL rst_pre_sel: got %0b want 1", sel); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin errors++; $display("FAIL rst_async_out: got v=%0b d=%0h l=%0b want 0 0 0", out_valid, out_data, out_last); end
        checks++; if (sel !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL rst_async_ctrl: got sel=%0b b_ready=%0b want 0 0", sel, b_ready); end
        b_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        m_prio = 1'b0;
        @(posedge clk);
        #1;
        // Fresh arbitration after reset: a tie must go to A.
        push_pkt(0, 1, 8'h41, 0);
        push_pkt(1, 1, 8'h42, 0);
        build_expected(a_q, b_q);
        run(100, 0, 0, 50);
        checks++; if (timed_out) begin errors++; $display("FAIL rst_timeout: got timeout want completion"); end
        checks++; if (rx.size() != 2 || rx[0].d !== 8'h41 || acc_ch[0] !== 1'b0) begin errors++; $display("FAIL rst_fresh_grant: got n=%0d first=%0h want n=2 first=41", rx.size(), rx.size() > 0 ? rx[0].d : 8'h00); end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_tie();
        logic [7:0] want [4] = '{8'h11, 8'h12, 8'h21, 8'h22};
        bit         wch  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        push_pkt(0, 2, 8'h11, 0);
        push_pkt(1, 2, 8'h21, 0);
        build_expected(a_q, b_q);
        run(100, 0, 0, 50);
        checks++;
        if (timed_out || rx.size() != 4 || acc_sel.size() != 4) begin
            errors++; $display("FAIL tie_count: got %0d beats want 4", rx.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rx[k].d !== want[k] || rx[k].l !== 1'(k % 2) || acc_sel[k] !== wch[k]) begin
                    errors++;
                    $display("FAIL tie_beat%0d: got d=%0h l=%0b sel=%0b want d=%0h l=%0b sel=%0b",
                             k, rx[k].d, rx[k].l, acc_sel[k], want[k], 1'(k % 2), wch[k]);
                end
            end
        end
        $display("test_tie done: beats=%0d errors=%0d", rx.size(), errors);
    endtask

    task automatic test_round_robin();
        bit grants[$];
        for (int r = 0; r < 3; r++) begin
            push_pkt(0, 2, 8'hA0 + 8'(4 * r), 0);
            push_pkt(1, 1, 8'hB0 + 8'(r), 0);
        end
        build_expected(a_q, b_q);
        run(100, 0, 0, 100);
        for (int k = 0; k < acc_last.size(); k++) if (acc_last[k]) grants.push_back(acc_ch[k]);
        checks++;
        if (timed_out || grants.size() != 6 || grants[0] !== 1'b0 || grants[1] !== 1'b1 || grants[2] !== 1'b0) begin
            errors++;
            $display("FAIL rr_order: got n=%0d g0..2=%0b%0b%0b want n=6 g0..2=010", grants.size(),
                     grants.size() > 0 ? grants[0] : 1'b0, grants.size() > 1 ? grants[1] : 1'b0,
                     grants.size() > 2 ? grants[2] : 1'b0);
        end
        checks++;
        if (rx.size() != exp_q.size()) begin
            errors++; $display("FAIL rr_count: got %0d want %0d", rx.size(), exp_q.size());
        end else begin
            for (int k = 0; k < rx.size(); k++) begin
                checks++;
                if (rx[k].d !== exp_q[k].d || rx[k].l !== exp_q[k].l || acc_ch[k] !== exp_q[k].ch) begin
                    errors++;
                    $display("FAIL rr_beat%0d: got d=%0h ch=%0b want d=%0h ch=%0b", k, rx[k].d, acc_ch[k], exp_q[k].d, exp_q[k].ch);
                end
            end
        end
        $display("test_round_robin done: packets=%0d errors=%0d", grants.size(), errors);
    endtask

    task automatic test_backpressure();
        push_pkt(0, 3, 8'h5A, 0);
        build_expected(a_q, b_q);
        run(100, 5, 0, 50);
        checks++;
        if (timed_out || snaps.size() < 8) begin
            errors++; $display("FAIL bp_timeout: got %0d cycles want >= 8", snaps.size());
        end else begin
            for (int c = 2; c <= 4; c++) begin
                checks++;
                if (snaps[c].ov !== 1'b1 || snaps[c].od !== 8'h5A || snaps[c].ar !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold_c%0d: got v=%0b d=%0h a_ready=%0b want v=1 d=5a a_ready=0", c, snaps[c].ov, snaps[c].od, snaps[c].ar);
                end
            end
        end
        checks++;
        if (rx.size() != 3 || rx[0].d !== 8'h5A || rx[1].d !== 8'h5B || rx[2].d !== 8'h5C || rx[2].l !== 1'b1) begin
            errors++; $display("FAIL bp_data: got %0d beats want 5a 5b 5c", rx.size());
        end else begin
            checks++;
            if (rx_cyc[0] != 5 || rx_cyc[1] != 6 || rx_cyc[2] != 7) begin
                errors++; $display("FAIL bp_throughput: got cycles %0d %0d %0d want 5 6 7", rx_cyc[0], rx_cyc[1], rx_cyc[2]);
            end
        end
        $display("test_backpressure done: beats=%0d errors=%0d", rx.size(), errors);
    endtask

    task automatic test_no_interleave();
        int first_br = -1;
        push_pkt(0, 4, 8'h31, 0);
        push_pkt(1, 2, 8'h71, 0);
        run(100, 0, 2, 50);
        m_prio = 1'b0;
        for (int c = 0; c < snaps.size(); c++) if (snaps[c].br && first_br < 0) first_br = c;
        checks++;
        if (timed_out || snaps.size() < 8 || snaps[2].bv !== 1'b1) begin
            errors++; $display("FAIL ni_setup: got %0d cycles want b_valid high at cycle 2", snaps.size());
        end
        checks++;
        if (first_br != 6) begin
            errors++; $display("FAIL ni_b_ready: got first b_ready cycle %0d want 6", first_br);
        end
        checks++;
        if (rx.size() != 6 || rx[3].d !== 8'h34 || rx[3].l !== 1'b1 || rx[4].d !== 8'h71 || rx[5].d !== 8'h72) begin
            errors++; $display("FAIL ni_order: got %0d beats want 31 32 33 34 71 72", rx.size());
        end
        $display("test_no_interleave done: first_b_ready=%0d errors=%0d", first_br, errors);
    endtask

    task automatic test_single_beat();
        push_pkt(0, 1, 8'hFF, 0);
        build_expected(a_q, b_q);
        run(100, 0, 0, 20);
        checks++;
        if (timed_out || snaps.size() < 3) begin
            errors++; $display("FAIL sb_timeout: got %0d cycles want >= 3", snaps.size());
        end else begin
            checks++;
            if (snaps[1].ov !== 1'b0 || snaps[2].ov !== 1'b1 || snaps[2].od !== 8'hFF || snaps[2].ol !== 1'b1) begin
                errors++;
                $display("FAIL sb_latency: got c1 v=%0b c2 v=%0b d=%0h l=%0b want 0 1 ff 1", snaps[1].ov, snaps[2].ov, snaps[2].od, snaps[2].ol);
            end
            checks++;
            if (snaps[2].ar !== 1'b0 || snaps[2].br !== 1'b0) begin
                errors++; $display("FAIL sb_idle: got a_ready=%0b b_ready=%0b want 0 0", snaps[2].ar, snaps[2].br);
            end
        end
        $display("test_single_beat done: errors=%0d", errors);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int na = $urandom_range(4);
            int nb = $urandom_range(4);
            int pct = $urandom_range(90, 30);
            int bad_hold = 0;
            int bad_excl = 0;
            int bad_sel = 0;
            int bad_beat = 0;
            for (int p = 0; p < na; p++) push_pkt(0, $urandom_range(4, 1), 8'h00, 1);
            for (int p = 0; p < nb; p++) push_pkt(1, $urandom_range(4, 1), 8'h00, 1);
            build_expected(a_q, b_q);
            run(pct, 0, 0, 3000);
            for (int c = 1; c < snaps.size(); c++) begin
                if (snaps[c-1].ov && !snaps[c-1].ordy &&
                    (!snaps[c].ov || snaps[c].od !== snaps[c-1].od || snaps[c].ol !== snaps[c-1].ol)) bad_hold++;
                if (snaps[c].ar && snaps[c].br) bad_excl++;
            end
            for (int k = 0; k < acc_sel.size(); k++) if (acc_sel[k] !== acc_ch[k]) bad_sel++;
            checks++;
            if (timed_out || rx.size() != exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count: got %0d beats want %0d", it, rx.size(), exp_q.size());
            end else begin
                for (int k = 0; k < rx.size(); k++)
                    if (rx[k].d !== exp_q[k].d || rx[k].l !== exp_q[k].l || acc_ch[k] !== exp_q[k].ch) bad_beat++;
                checks++;
                if (bad_beat != 0) begin errors++; $display("FAIL rand%0d_beats: got %0d wrong beats want 0", it, bad_beat); end
            end
            checks++; if (bad_hold != 0) begin errors++; $display("FAIL rand%0d_hold: got %0d unstable stalls want 0", it, bad_hold); end
            checks++; if (bad_excl != 0) begin errors++; $display("FAIL rand%0d_excl: got %0d dual-ready cycles want 0", it, bad_excl); end
            checks++; if (bad_sel != 0) begin errors++; $display("FAIL rand%0d_sel: got %0d sel mismatches want 0", it, bad_sel); end
            $display("test_random iter %0d: a_pkts=%0d b_pkts=%0d beats=%0d pct=%0d", it, na, nb, rx.size(), pct);
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_round_robin();
        test_backpressure();
        test_no_interleave();
        test_single_beat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
